pulse_capture: RTL and testbench

PULSE_CAPTURE -- requirements
Module: pulse_capture

---
 rtl/pcap_pkg.sv | 31 +++
 rtl/pcap_fifo.sv | 65 ++++++
 rtl/pulse_capture.sv | 147 ++++++++++++++
 tb/tb_pulse_capture.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcap_pkg.sv
// Shared types and constants for the pulse_capture block: entry layout,
// read-data bit positions and the read handshake state encoding.
package pcap_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int TS_W_DEF   = 24;
  localparam int TS_W_MAX   = 24;
  localparam int RD_W       = 32;
  localparam int RD_POL_BIT = 31;
  localparam int RD_TS_LSB  = 0;

  // Timestamp field is sized for the widest build; narrower builds zero-extend.
  typedef struct packed {
    logic                pol;
    logic [TS_W_MAX-1:0] ts;
  } pcap_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_e;

  function automatic logic [RD_W-1:0] pack_rd_data(input pcap_entry_t e);
    logic [RD_W-1:0] r;
    r = '0;
    r[RD_POL_BIT] = e.pol;
    r[RD_TS_LSB +: TS_W_MAX] = e.ts;
    return r;
  endfunction

endpackage

// File: rtl/pcap_fifo.sv
// Circular FIFO of captured edge entries with fill-level counter.
// The head entry is presented combinationally so a pop can load it directly.
module pcap_fifo
  import pcap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  pcap_entry_t              i_wdata,
  output pcap_entry_t              o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pcap_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pulse_capture.sv
// Edge timestamp capture: detects edges of pulse_i while enabled, queues
// {polarity, timestamp} and serves them through a req/ack read port.
// Optional macro PCAP_SYNC_EN inserts a 2-flop synchronizer on pulse_i.
module pulse_capture
  import pcap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    pulse_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    rd_req_i,
  output logic                    rd_ack_o,
  output logic [RD_W-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    ovf_o
);

  logic w_pulse;

`ifdef PCAP_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pulse_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pulse = r_sync2;
`else
  assign w_pulse = pulse_i;
`endif

  logic [TS_W-1:0] r_ts;
  logic            r_prev;
  logic            r_ovf;
  logic [RD_W-1:0] r_rd_data;
  rd_state_e       r_state;
  rd_state_e       w_state_next;

  logic            w_edge;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  pcap_entry_t     w_entry;
  pcap_entry_t     w_fifo_rdata;

  // Clear wins over everything, so it masks both the edge and the pop.
  assign w_edge = en_i & (w_pulse ^ r_prev) & ~clr_i;
  assign w_pop  = (r_state == ST_IDLE) & rd_req_i & ~w_fifo_empty & ~clr_i;
  assign w_push = w_edge & (~w_fifo_full | w_pop);
  assign w_drop = w_edge & w_fifo_full & ~w_pop;

  always_comb begin
    w_entry     = '0;
    w_entry.pol = w_pulse;
    w_entry.ts  = TS_W_MAX'(r_ts);
  end

  pcap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_clr   (clr_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_entry),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (count_o)
  );

  // The previous sample tracks pulse_i even while disabled, so enabling
  // during a high level does not look like a rising edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_prev <= 1'b0;
      r_ts   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_prev <= w_pulse;
      if (clr_i) begin
        r_ts  <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (en_i) begin
          r_ts <= r_ts + TS_W'(1);
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_rd_data <= pack_rd_data(w_fifo_rdata);
      end
    end
  end

  // ACK always lasts one cycle, so a held request pops at most every other cycle.
  always_comb begin
    w_state_next = r_state;
    rd_ack_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        rd_ack_o     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (clr_i) begin
      w_state_next = ST_IDLE;
    end
  end

  assign rd_data_o = r_rd_data;
  assign empty_o   = w_fifo_empty;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random phase.
module tb_pulse_capture;

  localparam int DEPTH = 16;
  localparam int TS_W  = 24;
  localparam int CW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n  = 1'b0;
  logic          pulse  = 1'b0;
  logic          en     = 1'b0;
  logic          clr    = 1'b0;
  logic          rd_req = 1'b0;
  logic          ack;
  logic [31:0]   data;
  logic [CW-1:0] count;
  logic          empty;
  logic          ovf;

  logic          pulse2 = 1'b0;
  logic          en2    = 1'b0;
  logic          clr2   = 1'b0;
  logic          rd2    = 1'b0;
  logic          ack2;
  logic [31:0]   data2;
  logic [CW-1:0] count2;
  logic          empty2;
  logic          ovf2;

  pulse_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .pulse_i (pulse), .en_i (en),
    .clr_i (clr), .rd_req_i (rd_req), .rd_ack_o (ack), .rd_data_o (data),
    .count_o (count), .empty_o (empty), .ovf_o (ovf)
  );

  pulse_capture #(.DEPTH(DEPTH), .TS_W(8)) dut8 (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .pulse_i (pulse2), .en_i (en2),
    .clr_i (clr2), .rd_req_i (rd2), .rd_ack_o (ack2), .rd_data_o (data2),
    .count_o (count2), .empty_o (empty2), .ovf_o (ovf2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (dut, TS_W=24) ----------------
  logic [31:0] mq[$];
  int          m_ts   = 0;
  bit          m_prev = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_ovf  = 1'b0;
  logic [31:0] m_data = 32'h0;
  bit          m_s1   = 1'b0;
  bit          m_s2   = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ts = 0; m_prev = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
      m_data = 32'h0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin : step
      bit p;
      bit popping;
      int sz0;
`ifdef PCAP_SYNC_EN
      p = m_s2; m_s2 = m_s1; m_s1 = pulse;
`else
      p = pulse;
`endif
      if (clr) begin
        mq.delete();
        m_ts = 0; m_ovf = 1'b0; m_busy = 1'b0;
      end else begin
        sz0     = mq.size();
        popping = !m_busy && rd_req && (sz0 > 0);
        m_busy  = popping;
        if (popping) m_data = mq.pop_front();
        if (en && (p != m_prev)) begin
          if (sz0 < DEPTH || popping) mq.push_back((p ? 32'h8000_0000 : 32'h0) | 32'(m_ts));
          else m_ovf = 1'b1;
        end
        if (en) m_ts = (m_ts + 1) % (1 << TS_W);
      end
      m_prev = p;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("ovf",   32'(ovf),   32'(m_ovf));
    chk("ack",   32'(ack),   32'(m_busy));
    chk("data",  data,       m_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_any(input string name, input bit check, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc(1);
      got = ack;
    end
    rd_req = 1'b0;
    chk({name, "_ack"}, 32'(got), 32'h1);
    if (check) chk({name, "_data"}, data, exp);
    $display("read %s: data=0x%08h", name, data);
    cyc(1);
    chk({name, "_ack_1cyc"}, 32'(ack), 32'h0);
  endtask

  task automatic rd2_chk(input string name, input logic [31:0] exp);
    bit got;
    got = 1'b0;
    rd2 = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc(1);
      got = ack2;
    end
    rd2 = 1'b0;
    chk({name, "_ack"}, 32'(got), 32'h1);
    chk({name, "_data"}, data2, exp);
    $display("read %s: data=0x%08h", name, data2);
    cyc(1);
    chk({name, "_ack_1cyc"}, 32'(ack2), 32'h0);
  endtask

  // Clear, then enable; each edge k lands at cycle 2k+1 after the clear.
  task automatic edges(input int n);
    clr = 1'b1; en = 1'b0; pulse = 1'b0;
    cyc(1);
    clr = 1'b0; en = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc(1);
      pulse = ~pulse;
      cyc(1);
    end
    en = 1'b0;
    cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_ovf",   32'(ovf),   32'h0);
    chk("rst_ack",   32'(ack),   32'h0);
    chk("rst_data",  data,       32'h0);
    chk("rst8_count", 32'(count2), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // TS_W=8 wrap: rising edge at timestamp 255, falling at 0
    en2 = 1'b1;
    cyc(255);
    pulse2 = 1'b1;
    cyc(1);
    pulse2 = 1'b0;
    cyc(1);
    en2 = 1'b0;
    cyc(1);
    chk("wrap_count", 32'(count2), 32'h2);
    rd2_chk("wrap0", 32'h8000_00FF);
    rd2_chk("wrap1", 32'h0000_0000);

    // basic capture
    clr = 1'b1; cyc(1); clr = 1'b0;
    en = 1'b1;
    cyc(10); pulse = 1'b1;
    cyc(4);  pulse = 1'b0;
    cyc(1);  en = 1'b0;
    cyc(1);
    chk("s1_count", 32'(count), 32'h2);
    rd_any("s1_r0", 1'b1, 32'h8000_000A);
    rd_any("s1_r1", 1'b1, 32'h0000_000E);
    chk("s1_empty", 32'(empty), 32'h1);

    // enable while pulse already high
    pulse = 1'b1; cyc(2);
    en = 1'b1;    cyc(5);
    chk("s2_count", 32'(count), 32'h0);
    chk("s2_empty", 32'(empty), 32'h1);
    en = 1'b0; cyc(1);
    pulse = 1'b0; cyc(1);

    // overflow: 17 edges into 16 entries
    edges(17);
    chk("s3_count", 32'(count), 32'd16);
    chk("s3_ovf",   32'(ovf),   32'h1);
    for (int k = 0; k < 16; k++) begin
      rd_any($sformatf("s3_r%0d", k), 1'b1,
             ((k % 2 == 0) ? 32'h8000_0000 : 32'h0) | 32'(2 * k + 1));
    end

    // push and pop in the same cycle while full
    edges(16);
    chk("s4_full", 32'(count), 32'd16);
    en = 1'b1; rd_req = 1'b1; pulse = ~pulse;
    cyc(1);
    rd_req = 1'b0; en = 1'b0;
    chk("s4_count", 32'(count), 32'd16);
    chk("s4_ack",   32'(ack),   32'h1);
    chk("s4_ovf",   32'(ovf),   32'h0);
    cyc(1);

    // clear with 5 entries and overflow set
    edges(17);
    for (int k = 0; k < 11; k++) rd_any("s5_drain", 1'b0, 32'h0);
    chk("s5_pre_count", 32'(count), 32'd5);
    chk("s5_pre_ovf",   32'(ovf),   32'h1);
    en = 1'b1; clr = 1'b1; rd_req = 1'b1; pulse = 1'b0;
    cyc(1);
    clr = 1'b0; rd_req = 1'b0;
    chk("s5_count", 32'(count), 32'h0);
    chk("s5_ovf",   32'(ovf),   32'h0);
    chk("s5_ack0",  32'(ack),   32'h0);
    cyc(1);
    chk("s5_ack1",  32'(ack),   32'h0);
    cyc(1);
    pulse = 1'b1;
    cyc(1);
    en = 1'b0;
    cyc(1);
    rd_any("s5_ts", 1'b1, 32'h8000_0002);

    // reset during ACK
    en = 1'b1; pulse = 1'b0; cyc(1);
    en = 1'b0; cyc(1);
    rd_req = 1'b1;
    for (int i = 0; i < 8 && !ack; i++) cyc(1);
    chk("s6_in_ack", 32'(ack), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("s6_count", 32'(count), 32'h0);
    chk("s6_empty", 32'(empty), 32'h1);
    chk("s6_ovf",   32'(ovf),   32'h0);
    chk("s6_ack",   32'(ack),   32'h0);
    chk("s6_data",  data,       32'h0);
    rd_req = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("s6_no_ack", 32'(ack), 32'h0);

    // randomized traffic, checked by the model every cycle
    clr = 1'b1; cyc(1); clr = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      int rd_rate;
      rd_rate = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 3 : 1);
      for (int c = 0; c < 500; c++) begin
        en     = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 2) == 0) pulse = ~pulse;
        rd_req = ($urandom_range(0, rd_rate) == 0);
        clr    = ($urandom_range(0, 299) == 0);
        cyc(1);
      end
      $display("random segment %0d: count=%0d ovf=%0d", seg, count, ovf);
    end
    en = 1'b0; rd_req = 1'b0; clr = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
